ex_div_unit: RTL and testbench



---
 rtl/div_pkg.sv | 10 +
 rtl/div_step.sv | 22 ++
 rtl/ex_div_unit.sv | 127 ++++++++++++
 tb/tb_ex_div_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the execute-stage divider.
package div_pkg;
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    localparam logic [2:0]  F3_DIV  = 3'b100;
    localparam logic [2:0]  F3_DIVU = 3'b101;
    localparam logic [2:0]  F3_REM  = 3'b110;
    localparam logic [2:0]  F3_REMU = 3'b111;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
endpackage

// File: rtl/div_step.sv
// One restoring division iteration on {R,Q} against divisor D.
// Combinational, zero latency, no flow control.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] r_in,
    input  logic [XLEN-1:0] q_in,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] r_out,
    output logic [XLEN-1:0] q_out
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    logic          take;

    assign shifted = {r_in, q_in[XLEN-1]};
    assign trial   = shifted - {1'b0, d};
    // A set carry-out bit means shifted already exceeds any XLEN-bit divisor.
    assign take    = shifted[XLEN] | ~trial[XLEN];
    assign r_out   = take ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    assign q_out   = {q_in[XLEN-2:0], take};
endmodule

// File: rtl/ex_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: start to ready 35 cycles (2 for /0 and overflow).
// Backpressure: stall holds upstream from the start cycle until the ready cycle.
module ex_div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start_sdivide,
    input  logic            start_udivide,
    input  logic [XLEN-1:0] ea,
    input  logic [XLEN-1:0] eb,
    input  logic [2:0]      efunc3,
    input  logic [4:0]      erd,
    input  logic            cancel,
    output logic            stall,
    output logic            ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      res_rd
);
    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [XLEN-1:0] a_reg, b_reg;
    logic [XLEN-1:0] rem_r, quo_r, dvs_r;
    logic [XLEN-1:0] rem_nx, quo_nx;
    logic [4:0]      rd_r;
    logic            sgn_r, rem_sel, qs_r, rs_r;
    logic            start;
    logic [XLEN-1:0] a_abs, b_abs, q_fix, r_fix;
    logic            b_zero, ovf;
    logic            unused_sig;

    assign unused_sig = ^{efunc3[2], efunc3[0], F3_DIV, F3_DIVU, F3_REM, F3_REMU, INT_MIN};

    assign start = start_sdivide | start_udivide;
    assign stall = (start && (state == IDLE || state == DONE)) ||
                   state == PREP || state == ITER || state == FIX;

    assign a_abs  = (sgn_r && a_reg[XLEN-1]) ? -a_reg : a_reg;
    assign b_abs  = (sgn_r && b_reg[XLEN-1]) ? -b_reg : b_reg;
    assign b_zero = (b_reg == '0);
    assign ovf    = sgn_r && (a_reg == {1'b1, {(XLEN-1){1'b0}}}) && (b_reg == '1);
    assign q_fix  = qs_r ? -quo_r : quo_r;
    assign r_fix  = rs_r ? -rem_r : rem_r;

    div_step #(.XLEN(XLEN)) u_step (
        .r_in  (rem_r),
        .q_in  (quo_r),
        .d     (dvs_r),
        .r_out (rem_nx),
        .q_out (quo_nx)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            cnt     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
            dvs_r   <= '0;
            rd_r    <= '0;
            sgn_r   <= 1'b0;
            rem_sel <= 1'b0;
            qs_r    <= 1'b0;
            rs_r    <= 1'b0;
            ready   <= 1'b0;
            result  <= '0;
            res_rd  <= '0;
        end else if (cancel) begin
            state <= IDLE;
            ready <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    ready <= 1'b0;
                    if (start) begin
                        a_reg   <= ea;
                        b_reg   <= eb;
                        rem_sel <= efunc3[1];
                        sgn_r   <= start_sdivide;
                        rd_r    <= erd;
                        state   <= PREP;
                    end else begin
                        state <= IDLE;
                    end
                end
                PREP: begin
                    qs_r <= sgn_r & (a_reg[XLEN-1] ^ b_reg[XLEN-1]);
                    rs_r <= sgn_r & a_reg[XLEN-1];
                    if (b_zero || ovf) begin
                        if (b_zero)
                            result <= rem_sel ? a_reg : '1;
                        else
                            result <= rem_sel ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        res_rd <= rd_r;
                        ready  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        quo_r <= a_abs;
                        dvs_r <= b_abs;
                        rem_r <= '0;
                        cnt   <= '0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    rem_r <= rem_nx;
                    quo_r <= quo_nx;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNTW'(XLEN-1))
                        state <= FIX;
                end
                FIX: begin
                    result <= rem_sel ? r_fix : q_fix;
                    res_rd <= rd_r;
                    ready  <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_div_unit.sv
// Randomized bench for ex_div_unit against an arithmetic reference and cycle-count model.
module tb_ex_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        start_sdivide = 1'b0;
    logic        start_udivide = 1'b0;
    logic [31:0] ea = '0;
    logic [31:0] eb = '0;
    logic [2:0]  efunc3 = '0;
    logic [4:0]  erd = '0;
    logic        cancel = 1'b0;
    logic        stall, ready;
    logic [31:0] result;
    logic [4:0]  res_rd;

    int checks = 0;
    int errors = 0;

    ex_div_unit #(.XLEN(32), .CNTW(6)) dut (
        .clk           (clk),
        .clrn          (clrn),
        .start_sdivide (start_sdivide),
        .start_udivide (start_udivide),
        .ea            (ea),
        .eb            (eb),
        .efunc3        (efunc3),
        .erd           (erd),
        .cancel        (cancel),
        .stall         (stall),
        .ready         (ready),
        .result        (result),
        .res_rd        (res_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic sgn, input logic rem,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == INT_MIN && b == 32'hFFFF_FFFF) return rem ? 32'h0 : INT_MIN;
        if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
        return rem ? a % b : a / b;
    endfunction

    function automatic bit is_special(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (sgn && a == INT_MIN && b == 32'hFFFF_FFFF);
    endfunction

    // Behavioural model: cycles left until the ready pulse, plus the pending answer.
    int          m_left = 0;
    logic        m_ready = 1'b0;
    logic [31:0] m_res = '0, p_res = '0;
    logic [4:0]  m_rd = '0, p_rd = '0;
    logic        start_any;
    assign start_any = start_sdivide | start_udivide;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_left  <= 0;
            m_ready <= 1'b0;
            m_res   <= '0;
            m_rd    <= '0;
        end else if (cancel) begin
            m_left  <= 0;
            m_ready <= 1'b0;
        end else if (m_left > 0) begin
            m_left  <= m_left - 1;
            m_ready <= (m_left == 1);
            if (m_left == 1) begin
                m_res <= p_res;
                m_rd  <= p_rd;
            end
        end else begin
            m_ready <= 1'b0;
            if (start_any) begin
                p_res  <= ref_res(start_sdivide, efunc3[1], ea, eb);
                p_rd   <= erd;
                m_left <= is_special(start_sdivide, ea, eb) ? 1 : 34;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("cyc_ready", ready, m_ready);
        check("cyc_stall", stall, start_any | (m_left != 0));
        check("cyc_result", result, m_res);
        check("cyc_res_rd", res_rd, m_rd);
    end

    // Waits for ready; returns the cycle index (start cycle = 0) or -1 on timeout.
    task automatic wait_ready(input int limit, output int n, output logic [31:0] res,
                              output logic [4:0] rd);
        bit got = 0;
        n = 0;
        res = '0;
        rd = '0;
        while (!got && n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (ready) begin
                got = 1;
                res = result;
                rd = res_rd;
            end
            #2;
            if (n == 1) begin
                start_sdivide = 1'b0;
                start_udivide = 1'b0;
            end
        end
        if (!got) n = -1;
    endtask

    task automatic op(input logic s, input logic u, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] exp,
                      input int lat, input string nm, input bit b2b);
        int n;
        logic [31:0] r;
        logic [4:0] t;
        if (!b2b) begin
            @(posedge clk);
            #3;
        end
        start_sdivide = s;
        start_udivide = u;
        ea = a;
        eb = b;
        efunc3 = f3;
        erd = rd;
        #1;
        check({nm, "_stall0"}, stall, 1'b1);
        wait_ready(60, n, r, t);
        check({nm, "_lat"}, n, lat);
        check({nm, "_res"}, r, exp);
        check({nm, "_rd"}, t, rd);
    endtask

    initial begin
        int n;
        bit saw;
        logic [31:0] r;
        logic [4:0] t;

        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_res_rd", res_rd, 5'h0);
        #2;
        clrn = 1'b1;

        op(1, 0, 32'd100, 32'd7, F3_DIV, 5'd5, 32'd14, 35, "div_100_7", 0);
        op(1, 0, -32'sd100, 32'd7, F3_REM, 5'd3, 32'hFFFF_FFFE, 35, "rem_m100_7", 0);
        op(0, 1, 32'hFFFF_FFFF, 32'd2, F3_DIVU, 5'd7, 32'h7FFF_FFFF, 35, "divu_max_2", 0);
        op(1, 0, 32'h1234_5678, 32'd0, F3_DIV, 5'd8, 32'hFFFF_FFFF, 2, "div_by0", 0);
        op(0, 1, 32'h1234_5678, 32'd0, F3_REMU, 5'd9, 32'h1234_5678, 2, "remu_by0", 0);
        op(1, 0, INT_MIN, 32'hFFFF_FFFF, F3_DIV, 5'd10, INT_MIN, 2, "div_ovf", 0);
        op(1, 0, INT_MIN, 32'hFFFF_FFFF, F3_REM, 5'd11, 32'h0, 2, "rem_ovf", 0);

        // Cancel in cycle 10 of DIV 50/5.
        @(posedge clk);
        #3;
        start_sdivide = 1'b1;
        ea = 32'd50;
        eb = 32'd5;
        efunc3 = F3_DIV;
        erd = 5'd4;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (k == 11) begin
                check("cancel_stall", stall, 1'b0);
                check("cancel_ready", ready, 1'b0);
            end
            #2;
            if (k == 1) start_sdivide = 1'b0;
            if (k == 10) cancel = 1'b1;
            if (k == 11) cancel = 1'b0;
        end
        saw = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) saw = 1;
        end
        check("cancel_no_ready", saw, 1'b0);
        check("cancel_result_kept", result, 32'h0);
        op(0, 1, 32'd9, 32'd3, F3_DIVU, 5'd6, 32'd3, 35, "divu_after_cancel", 0);

        // Start pulsed mid-ITER must be ignored.
        @(posedge clk);
        #3;
        start_sdivide = 1'b1;
        ea = 32'd1000;
        eb = 32'd10;
        efunc3 = F3_DIV;
        erd = 5'd12;
        n = 0;
        saw = 0;
        r = '0;
        t = '0;
        while (!saw && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (ready) begin
                saw = 1;
                r = result;
                t = res_rd;
            end
            #2;
            if (n == 1) start_sdivide = 1'b0;
            if (n == 5) begin
                start_udivide = 1'b1;
                ea = 32'd7;
                eb = 32'd1;
                efunc3 = F3_DIVU;
                erd = 5'd20;
            end
            if (n == 6) start_udivide = 1'b0;
        end
        check("ignore_lat", saw ? n : -1, 35);
        check("ignore_res", r, 32'd100);
        check("ignore_rd", t, 5'd12);

        op(1, 0, 32'd77, 32'd7, F3_DIV, 5'd13, 32'd11, 35, "b2b_a", 0);
        op(0, 1, 32'd1000, 32'd3, F3_REMU, 5'd14, 32'd1, 35, "b2b_b", 1);

        // Asynchronous reset in the middle of ITER.
        @(posedge clk);
        #3;
        start_sdivide = 1'b1;
        ea = 32'd1234;
        eb = 32'd5;
        efunc3 = F3_DIV;
        erd = 5'd15;
        @(posedge clk);
        #3;
        start_sdivide = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        clrn = 1'b0;
        #1;
        check("arst_stall", stall, 1'b0);
        check("arst_ready", ready, 1'b0);
        check("arst_result", result, 32'h0);
        check("arst_res_rd", res_rd, 5'h0);
        @(posedge clk);
        #3;
        clrn = 1'b1;

        for (int i = 0; i < 40; i++) begin
            logic        s, u, rem;
            logic [31:0] a, b;
            logic [4:0]  rd;
            int          kind;
            kind = $urandom_range(0, 7);
            a = $urandom;
            b = (kind == 2) ? $urandom_range(1, 15) : $urandom;
            if (kind == 0) b = 32'h0;
            if (kind == 1) begin
                a = INT_MIN;
                b = 32'hFFFF_FFFF;
            end
            if (kind == 3) b = {28'h0, b[3:0]} | 32'h1;
            s = $urandom_range(0, 1);
            u = s ? ($urandom_range(0, 3) == 0) : 1'b1;
            rem = $urandom_range(0, 1);
            rd = 5'($urandom);
            op(s, u, a, b, {1'b1, rem, ~s}, rd, ref_res(s, rem, a, b),
               is_special(s, a, b) ? 2 : 35, "rand", bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
